// File: rtl/divider_4bit_seq.sv
// Sequential restoring divider: one quotient bit per clock.
// Q/R/div_by_zero are registered and change only on a done edge or on reset.
module divider_4bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    // Dividend bits shift out of the MSB while quotient bits shift into the
    // LSB, so after WIDTH steps this register holds the quotient.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // One restoring step. When trial >= divisor the difference fits in
    // WIDTH bits, so the subtraction only needs the low WIDTH bits.
    always_comb begin
        trial    = {rem_q, dvd_q[WIDTH-1]};
        ge       = (trial >= {1'b0, dvs_q});
        rem_sub  = trial[WIDTH-1:0] - dvs_q;
        rem_step = ge ? rem_sub : trial[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], ge};
    end

    // Next-state and datapath control; everything holds by default.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (Y != '0) begin
                        dvd_d   = X;
                        dvs_d   = Y;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = RUN;
                    end else begin
                        // Divide by zero resolves immediately without RUN.
                        q_d    = '1;
                        r_d    = X;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                if (cnt_q == '0) begin
                    q_d     = quo_step;
                    r_d     = rem_step;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
